// File: rtl/cga_vram_arbiter_pkg.sv
// Shared types and constants for the CGA video SRAM arbiter.
package cga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int CGA_VRAM_ADDR_W = 19;
  localparam int BEAT_W          = 3;

  function automatic logic [BEAT_W-1:0] last_beat(input int cycles);
    return BEAT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cga_vram_arbiter.sv
// Time-shares the video SRAM between slot-driven pixel fetch and posted ISA accesses.
// Optional macro CGA_SNOW_EN: ISA keeps the SRAM during a pixel slot and the pixel byte is corrupted (CGA snow).
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int ADDR_W       = CGA_VRAM_ADDR_W,
  parameter int ISA_CYCLES   = 2,
  parameter bit USE_BUS_WAIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              pixel_read,
  input  logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_data,
  input  logic              isa_op_enable,
  input  logic              isa_read,
  input  logic              isa_write,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [7:0]        isa_din,
  output logic [7:0]        isa_dout,
  output logic              isa_rdy,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic              ram_oe,
  output logic              ram_we_l
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = last_beat(ISA_CYCLES);

  arb_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              strobe_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        pixel_data_q, pixel_data_d;
  logic [7:0]        isa_dout_q, isa_dout_d;
  logic              isa_rdy_q, isa_rdy_d;

  logic              strobe_s;
  logic              rise_s;
  logic              isa_owns_s;
  logic [ADDR_W-1:0] ram_a_s;
  logic              ram_oe_s;
  logic              ram_we_l_s;

  assign strobe_s = isa_read | isa_write;
  assign rise_s   = strobe_s & ~strobe_q;

`ifdef CGA_SNOW_EN
  assign isa_owns_s = 1'b1;
`else
  assign isa_owns_s = ~pixel_read;
`endif

  // Next-state, SRAM pin steering and capture of read data.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    isa_dout_d   = isa_dout_q;
    isa_rdy_d    = isa_rdy_q;
    ram_a_s      = pixel_addr;
    ram_oe_s     = 1'b0;
    ram_we_l_s   = 1'b1;
    if (pixel_read) begin
      pixel_data_d = ram_din;
    end else begin
      pixel_data_d = pixel_data_q;
    end

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          addr_d    = isa_addr;
          wdata_d   = isa_din;
          is_wr_d   = isa_write;
          isa_rdy_d = 1'b0;
          state_d   = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (isa_op_enable && !pixel_read) begin
          beat_d  = {BEAT_W{1'b0}};
          state_d = ACCESS;
        end else begin
          state_d = PEND;
        end
      end
      ACCESS: begin
        if (isa_owns_s) begin
          ram_a_s    = addr_q;
          ram_oe_s   = is_wr_q;
          // Last write beat releases WE so address and data are held past the strobe.
          ram_we_l_s = ~(is_wr_q && (beat_q != LAST_BEAT));
          if (pixel_read) begin
            pixel_data_d = is_wr_q ? wdata_q : ram_din;
          end else begin
            pixel_data_d = pixel_data_q;
          end
          if (beat_q == LAST_BEAT) begin
            if (!is_wr_q) begin
              isa_dout_d = ram_din;
            end else begin
              isa_dout_d = isa_dout_q;
            end
            isa_rdy_d = 1'b1;
            state_d   = DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else begin
          beat_d  = {BEAT_W{1'b0}};
          state_d = PEND;
        end
      end
      DONE: begin
        if (!strobe_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      beat_q       <= {BEAT_W{1'b0}};
      strobe_q     <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= 8'h00;
      is_wr_q      <= 1'b0;
      pixel_data_q <= 8'h00;
      isa_dout_q   <= 8'h00;
      isa_rdy_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      strobe_q     <= strobe_s;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      pixel_data_q <= pixel_data_d;
      isa_dout_q   <= isa_dout_d;
      isa_rdy_q    <= isa_rdy_d;
    end
  end

  // Pins must be steered within the slot cycle, so the SRAM side is combinational and parked during reset.
  assign ram_a      = reset_l ? ram_a_s : {ADDR_W{1'b0}};
  assign ram_oe     = reset_l ? ram_oe_s : 1'b0;
  assign ram_we_l   = reset_l ? ram_we_l_s : 1'b1;
  assign ram_dout   = wdata_q;
  assign pixel_data = pixel_data_q;
  assign isa_dout   = isa_dout_q;
  assign isa_rdy    = isa_rdy_q | ~USE_BUS_WAIT;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Self-checking bench for cga_vram_arbiter with an SRAM model and a transaction-level reference.
module tb_cga_vram_arbiter;
  import cga_pkg::*;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          pixel_read;
  logic [AW-1:0] pixel_addr;
  logic [7:0]    pixel_data;
  logic          isa_op_enable;
  logic          isa_read;
  logic          isa_write;
  logic [AW-1:0] isa_addr;
  logic [7:0]    isa_din;
  logic [7:0]    isa_dout;
  logic          isa_rdy;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic          ram_oe;
  logic          ram_we_l;

  logic [7:0]    pixel_data_nw, isa_dout_nw, ram_din_nw, ram_dout_nw;
  logic          isa_rdy_nw, ram_oe_nw, ram_we_l_nw;
  logic [AW-1:0] ram_a_nw;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ref_mem [int];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int rdy2_bad = 0;
  int auto_mode = 0;
  bit pix_chk_en = 1'b0;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  always #5 clk = ~clk;

  cga_vram_arbiter #(.ADDR_W(AW), .ISA_CYCLES(2), .USE_BUS_WAIT(1'b1)) u_dut (
    .clk(clk), .reset_l(reset_l),
    .pixel_read(pixel_read), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .isa_op_enable(isa_op_enable), .isa_read(isa_read), .isa_write(isa_write),
    .isa_addr(isa_addr), .isa_din(isa_din), .isa_dout(isa_dout), .isa_rdy(isa_rdy),
    .ram_a(ram_a), .ram_din(ram_din), .ram_dout(ram_dout), .ram_oe(ram_oe), .ram_we_l(ram_we_l)
  );

  cga_vram_arbiter #(.ADDR_W(AW), .ISA_CYCLES(2), .USE_BUS_WAIT(1'b0)) u_dut_nw (
    .clk(clk), .reset_l(reset_l),
    .pixel_read(pixel_read), .pixel_addr(pixel_addr), .pixel_data(pixel_data_nw),
    .isa_op_enable(isa_op_enable), .isa_read(isa_read), .isa_write(isa_write),
    .isa_addr(isa_addr), .isa_din(isa_din), .isa_dout(isa_dout_nw), .isa_rdy(isa_rdy_nw),
    .ram_a(ram_a_nw), .ram_din(ram_din_nw), .ram_dout(ram_dout_nw), .ram_oe(ram_oe_nw),
    .ram_we_l(ram_we_l_nw)
  );

  assign ram_din    = mem[ram_a];
  assign ram_din_nw = mem[ram_a_nw];

  // SRAM model (sole writer of mem) plus per-slot pixel data check.
  initial begin : sram_model
    logic          s_we;
    logic [AW-1:0] s_a;
    logic [7:0]    s_d;
    logic          s_pr;
    logic [7:0]    s_exp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
    mem[19'h07FFF] = 8'h3C;
    mem[19'h01111] = 8'h5A;
    forever begin
      @(negedge clk);
      #2;
      s_we  = ram_we_l;
      s_a   = ram_a;
      s_d   = ram_dout;
      s_pr  = pixel_read;
      s_exp = mem[pixel_addr];
      if (reset_l === 1'b1 && isa_rdy_nw !== 1'b1) rdy2_bad++;
      @(posedge clk);
      if (reset_l === 1'b1 && s_we === 1'b0) begin
        mem[s_a] <= s_d;
        we_cnt++;
      end
      #1;
      if (pix_chk_en && s_pr === 1'b1) begin
        checks++;
        if (pixel_data !== s_exp) begin
          errors++;
          $display("FAIL pixel_slot: pixel_data=%h required %h", pixel_data, s_exp);
        end
      end
    end
  end

  // Sequencer emulation: fixed slot pattern (mode 1) or random slots (mode 2).
  initial begin : sequencer
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (auto_mode == 1) begin
        pixel_read    = (ph < 5) && (ph % 2 == 0);
        isa_op_enable = (ph == 5);
        pixel_addr    = AW'($urandom);
        ph            = (ph + 1) % 8;
      end else if (auto_mode == 2) begin
        pixel_read    = ($urandom_range(0, 3) == 0);
        pixel_addr    = AW'($urandom);
        isa_op_enable = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_rdy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (isa_rdy !== lvl && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (isa_rdy !== lvl) begin
      errors++;
      $display("FAIL %s: isa_rdy=%b required %b within %0d clks", name, isa_rdy, lvl, budget);
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0; pixel_read = 1'b1; pixel_addr = 19'h00010; isa_op_enable = 1'b0;
    isa_read = 1'b0; isa_write = 1'b0; isa_addr = '0; isa_din = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (isa_rdy !== 1'b1 || ram_we_l !== 1'b1 || ram_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/we_l/oe=%b%b%b required 110", isa_rdy, ram_we_l, ram_oe);
    end
    checks++;
    if (pixel_data !== 8'h00 || isa_dout !== 8'h00 || ram_a !== 19'h0) begin
      errors++;
      $display("FAIL reset_data: pixel_data=%h isa_dout=%h ram_a=%h required 00 00 0", pixel_data, isa_dout, ram_a);
    end
    @(negedge clk);
    reset_l = 1'b1; pixel_read = 1'b0; pixel_addr = 19'h00abc;
    #1;
    checks++;
    if (ram_a !== 19'h00abc) begin
      errors++;
      $display("FAIL idle_bus: ram_a=%h required 00abc", ram_a);
    end
  endtask

  task automatic test_write();
    int base;
    auto_mode = 0; pix_chk_en = 1'b1; isa_op_enable = 1'b0; pixel_read = 1'b0;
    base = we_cnt;
    @(negedge clk);
    isa_addr = 19'h00123; isa_din = 8'hA5; isa_write = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (isa_rdy !== 1'b0) begin
      errors++; $display("FAIL wr_rdy_low: isa_rdy=%b required 0", isa_rdy);
    end
    repeat (3) @(negedge clk);
    isa_op_enable = 1'b1;
    #1;
    checks++;
    if (we_cnt != base || isa_rdy !== 1'b0) begin
      errors++; $display("FAIL wr_wait_window: writes=%0d rdy=%b required 0 0", we_cnt - base, isa_rdy);
    end
    @(negedge clk);
    isa_op_enable = 1'b0;
    #1;
    checks++;
    if (ram_we_l !== 1'b0 || ram_oe !== 1'b1 || ram_a !== 19'h00123 || ram_dout !== 8'hA5) begin
      errors++;
      $display("FAIL wr_beat0: we_l=%b oe=%b a=%h d=%h required 0 1 00123 a5", ram_we_l, ram_oe, ram_a, ram_dout);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ram_we_l !== 1'b1 || ram_oe !== 1'b1 || ram_a !== 19'h00123) begin
      errors++; $display("FAIL wr_beat1: we_l=%b oe=%b a=%h required 1 1 00123", ram_we_l, ram_oe, ram_a);
    end
    @(negedge clk);
    #1;
    checks++;
    if (isa_rdy !== 1'b1 || we_cnt - base != 1 || mem[19'h00123] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_done: rdy=%b writes=%0d mem=%h required 1 1 a5", isa_rdy, we_cnt - base, mem[19'h00123]);
    end
    isa_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_slots();
    int n, viol;
    bit seen_low;
    n = 0; viol = 0; seen_low = 1'b0;
    pix_chk_en = 1'b1;
    @(negedge clk);
    auto_mode = 1;
    isa_addr = 19'h07FFF; isa_read = 1'b1;
    while (n < 80 && !(seen_low && isa_rdy === 1'b1)) begin
      @(negedge clk);
      #1;
      n++;
      if (isa_rdy === 1'b0) seen_low = 1'b1;
      if (pixel_read === 1'b1 && (ram_a !== pixel_addr || ram_oe !== 1'b0 || ram_we_l !== 1'b1)) viol++;
    end
    checks++;
    if (!(seen_low && isa_rdy === 1'b1)) begin
      errors++; $display("FAIL rd_timeout: isa_rdy=%b required 1 within 80 clks", isa_rdy);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL rd_slot_owner: pixel slots lost=%0d required 0", viol);
    end
    checks++;
    if (isa_dout !== 8'h3C) begin
      errors++; $display("FAIL rd_data: isa_dout=%h required 3c", isa_dout);
    end
    isa_read = 1'b0; auto_mode = 0; pixel_read = 1'b0; isa_op_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int base;
    logic [7:0] exp_pix;
    int exp_wr;
`ifdef CGA_SNOW_EN
    exp_pix = 8'hA5; exp_wr = 1;
`else
    exp_pix = 8'h5A; exp_wr = 2;
`endif
    pix_chk_en = 1'b0; auto_mode = 0; isa_op_enable = 1'b1; pixel_read = 1'b0;
    base = we_cnt;
    @(negedge clk);
    isa_addr = 19'h0ABCD; isa_din = 8'hA5; isa_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ram_we_l !== 1'b0) begin
      errors++; $display("FAIL ab_beat0: we_l=%b required 0", ram_we_l);
    end
    @(negedge clk);
    pixel_read = 1'b1; pixel_addr = 19'h01111;
    #1;
    checks++;
`ifdef CGA_SNOW_EN
    if (ram_we_l !== 1'b1 || ram_oe !== 1'b1 || ram_a !== 19'h0ABCD) begin
      errors++; $display("FAIL ab_slot_pins: we_l=%b oe=%b a=%h required 1 1 0abcd", ram_we_l, ram_oe, ram_a);
    end
`else
    if (ram_we_l !== 1'b1 || ram_oe !== 1'b0 || ram_a !== 19'h01111) begin
      errors++; $display("FAIL ab_slot_pins: we_l=%b oe=%b a=%h required 1 0 01111", ram_we_l, ram_oe, ram_a);
    end
`endif
    @(negedge clk);
    pixel_read = 1'b0;
    #1;
    checks++;
    if (pixel_data !== exp_pix) begin
      errors++; $display("FAIL ab_pixel: pixel_data=%h required %h", pixel_data, exp_pix);
    end
    wait_rdy(1'b1, 20, "ab_done");
    checks++;
    if (we_cnt - base != exp_wr || mem[19'h0ABCD] !== 8'hA5) begin
      errors++;
      $display("FAIL ab_write: we cycles=%0d mem=%h required %0d a5", we_cnt - base, mem[19'h0ABCD], exp_wr);
    end
    isa_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held_strobe();
    int base;
    pix_chk_en = 1'b1; auto_mode = 0; isa_op_enable = 1'b1; pixel_read = 1'b0;
    base = we_cnt;
    @(negedge clk);
    isa_addr = 19'h00200; isa_din = 8'h11; isa_write = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (we_cnt - base != 1 || isa_rdy !== 1'b1) begin
      errors++; $display("FAIL held_once: writes=%0d rdy=%b required 1 1", we_cnt - base, isa_rdy);
    end
    isa_write = 1'b0;
    repeat (2) @(negedge clk);
    isa_din = 8'h22; isa_write = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (we_cnt - base != 2 || mem[19'h00200] !== 8'h22) begin
      errors++; $display("FAIL held_second: writes=%0d mem=%h required 2 22", we_cnt - base, mem[19'h00200]);
    end
    isa_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_posted();
    isa_op_enable = 1'b0;
    @(negedge clk);
    isa_addr = 19'h00300; isa_din = 8'h77; isa_write = 1'b1;
    repeat (2) @(negedge clk);
    isa_write = 1'b0;
    @(negedge clk);
    isa_op_enable = 1'b1;
    wait_rdy(1'b1, 10, "posted_done");
    checks++;
    if (mem[19'h00300] !== 8'h77) begin
      errors++; $display("FAIL posted_write: mem=%h required 77", mem[19'h00300]);
    end
    @(negedge clk);
    isa_read = 1'b1;
    wait_rdy(1'b0, 5, "posted_rd_start");
    wait_rdy(1'b1, 20, "posted_rd_done");
    checks++;
    if (isa_dout !== 8'h77) begin
      errors++; $display("FAIL posted_readback: isa_dout=%h required 77", isa_dout);
    end
    isa_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] a;
    logic [7:0]    d, exp_d;
`ifdef CGA_SNOW_EN
    pix_chk_en = 1'b0;
`else
    pix_chk_en = 1'b1;
`endif
    auto_mode = 2;
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 19'h40000 + AW'($urandom_range(0, 15));
      d  = 8'($urandom);
      @(negedge clk);
      isa_addr = a; isa_din = d; isa_write = wr; isa_read = ~wr;
      wait_rdy(1'b0, 5, "rnd_start");
      wait_rdy(1'b1, 300, "rnd_done");
      isa_write = 1'b0; isa_read = 1'b0;
      checks++;
      if (wr) begin
        ref_mem[int'(a)] = d;
        if (mem[a] !== d) begin
          errors++; $display("FAIL rnd_write[%0d]: mem[%h]=%h required %h", t, a, mem[a], d);
        end
      end else begin
        exp_d = ref_rd(a);
        if (isa_dout !== exp_d) begin
          errors++; $display("FAIL rnd_read[%0d]: isa_dout=%h required %h at %h", t, isa_dout, exp_d, a);
        end
      end
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    auto_mode = 0; pixel_read = 1'b0; isa_op_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_write();
    test_read_slots();
    test_abort();
    test_held_strobe();
    test_posted();
    test_random();
    checks++;
    if (rdy2_bad != 0) begin
      errors++; $display("FAIL nowait_rdy: cycles with isa_rdy low=%0d required 0", rdy2_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
